// File: rtl/ram_arb_pkg.sv
// Shared types for the arbitrated simple-dual-port RAM.
// FSM state encoding and the read client id.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef logic client_id_t;

  localparam client_id_t CLIENT0 = 1'b0;
  localparam client_id_t CLIENT1 = 1'b1;

endpackage

// File: rtl/ram_sdp_arb_if.sv
// Handshake bundle for ram_sdp_arb: clear, write port,
// two read clients and the shared read response.
interface ram_sdp_arb_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32
) ();
  localparam int AWIDTH = $clog2(DEPTH);

  logic              clear_req;
  logic              init_busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              rd0_valid;
  logic              rd1_valid;
  logic [AWIDTH-1:0] rd0_addr;
  logic [AWIDTH-1:0] rd1_addr;
  logic              rd0_ready;
  logic              rd1_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DWIDTH-1:0] rsp_data;

  modport master (
    output clear_req, wr_valid, wr_addr, wr_data,
    output rd0_valid, rd1_valid, rd0_addr, rd1_addr,
    input  init_busy, wr_ready, rd0_ready, rd1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  clear_req, wr_valid, wr_addr, wr_data,
    input  rd0_valid, rd1_valid, rd0_addr, rd1_addr,
    output init_busy, wr_ready, rd0_ready, rd1_ready,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/ram_sdp_one_clock.sv
// Single-clock simple-dual-port RAM storage array:
// synchronous write, asynchronous read, no reset.
module ram_sdp_one_clock #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_sdp_arb.sv
// Two-reader round-robin RAM with one write port,
// a clear sweep after reset/clear_req and write-to-read bypass.
module ram_sdp_arb
  import ram_arb_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32
) (
  input logic          clk,
  input logic          rst_n,
  ram_sdp_arb_if.slave bus
);
  localparam int AWIDTH = $clog2(DEPTH);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  state_e            state;
  logic [AWIDTH-1:0] clr_cnt;
  client_id_t        prio;
  logic              run;
  logic              gnt0;
  logic              gnt1;
  logic              gnt;
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;
  logic              hit;

  assign run = (state == RUN);

  // prio names the client that wins when both request
  assign gnt0 = run && bus.rd0_valid &&
                (!bus.rd1_valid || prio == CLIENT0);
  assign gnt1 = run && bus.rd1_valid &&
                (!bus.rd0_valid || prio == CLIENT1);
  assign gnt  = gnt0 || gnt1;

  assign bus.init_busy = !run;
  assign bus.wr_ready  = run;
  assign bus.rd0_ready = gnt0;
  assign bus.rd1_ready = gnt1;

  assign we    = run ? bus.wr_valid : 1'b1;
  assign waddr = run ? bus.wr_addr : clr_cnt;
  assign wdata = run ? bus.wr_data : '0;
  assign raddr = gnt1 ? bus.rd1_addr : bus.rd0_addr;
  assign hit   = we && (waddr == raddr);

  ram_sdp_one_clock #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (bus.clear_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST) begin
            clr_cnt <= '0;
            state   <= RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.clear_req) begin
            clr_cnt <= '0;
            state   <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio          <= CLIENT0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= CLIENT0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= gnt;
      if (gnt) begin
        prio         <= gnt1 ? CLIENT0 : CLIENT1;
        bus.rsp_id   <= gnt1;
        bus.rsp_data <= hit ? wdata : rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_arb.sv
// Directed bench for ram_sdp_arb (DWIDTH=64, DEPTH=32):
// clear sweeps, bypass, round-robin order and async reset.
module tb_ram_sdp_arb;
  localparam int DW = 64;
  localparam int DP = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   n;

  always #5 clk = ~clk;

  ram_sdp_arb_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  ram_sdp_arb #(
    .DWIDTH (DW),
    .DEPTH  (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [63:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    #1;
    chk("wr_ready", 64'(bus.wr_ready), 64'd1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic id,
                    input logic [4:0] a,
                    input logic [63:0] exp);
    if (id) begin
      bus.rd1_valid = 1'b1;
      bus.rd1_addr  = a;
    end else begin
      bus.rd0_valid = 1'b1;
      bus.rd0_addr  = a;
    end
    #1;
    chk("rd_gnt", 64'(id ? bus.rd1_ready
                         : bus.rd0_ready), 64'd1);
    step();
    bus.rd0_valid = 1'b0;
    bus.rd1_valid = 1'b0;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rsp_id", 64'(bus.rsp_id), 64'(id));
    chk("rsp_data", bus.rsp_data, exp);
  endtask

  task automatic busy_cnt(output int cnt);
    cnt = 0;
    while (bus.init_busy && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    bus.clear_req = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd0_valid = 1'b0;
    bus.rd1_valid = 1'b0;
    bus.rd0_addr  = '0;
    bus.rd1_addr  = '0;
    #3;
    chk("rst_busy", 64'(bus.init_busy), 64'd1);
    chk("rst_rsp_v", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_d", bus.rsp_data, 64'd0);
    chk("rst_wr_rdy", 64'(bus.wr_ready), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    busy_cnt(n);
    chk("sweep_len", 64'(n), 64'd32);

    for (int i = 0; i < DP; i++)
      rd(1'b0, 5'(i), 64'd0);

    // rd0 last granted: rd0 then rd1 leaves prio on 0
    wr(5'd5, 64'hDEAD_BEEF);
    rd(1'b0, 5'd5, 64'hDEAD_BEEF);

    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 64'h1234;
    rd(1'b1, 5'd7, 64'h1234);

    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd6;
    bus.wr_data  = 64'h66;
    rd(1'b1, 5'd7, 64'h1234);
    bus.wr_valid = 1'b0;
    rd(1'b1, 5'd6, 64'h66);

    bus.rd0_valid = 1'b1;
    bus.rd0_addr  = 5'd5;
    bus.rd1_valid = 1'b1;
    bus.rd1_addr  = 5'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_g0", 64'(bus.rd0_ready), 64'(k % 2 == 0));
      chk("rr_g1", 64'(bus.rd1_ready), 64'(k % 2 == 1));
      step();
      chk("rr_id", 64'(bus.rsp_id), 64'(k % 2));
      chk("rr_d", bus.rsp_data,
          (k % 2 == 0) ? 64'hDEAD_BEEF : 64'h1234);
    end
    bus.rd0_valid = 1'b0;
    bus.rd1_valid = 1'b0;
    step();
    chk("idle_v", 64'(bus.rsp_valid), 64'd0);
    chk("idle_id", 64'(bus.rsp_id), 64'd1);
    chk("idle_d", bus.rsp_data, 64'h1234);

    wr(5'd3, 64'hFF);
    rd(1'b0, 5'd3, 64'hFF);
    bus.clear_req = 1'b1;
    bus.rd0_valid = 1'b1;
    bus.rd0_addr  = 5'd3;
    #1;
    chk("clr_gnt", 64'(bus.rd0_ready), 64'd1);
    step();
    bus.clear_req = 1'b0;
    bus.rd0_valid = 1'b0;
    chk("clr_rsp_v", 64'(bus.rsp_valid), 64'd1);
    chk("clr_rsp_d", bus.rsp_data, 64'hFF);
    chk("clr_wr_rdy", 64'(bus.wr_ready), 64'd0);
    busy_cnt(n);
    chk("clr_len", 64'(n), 64'd32);
    rd(1'b0, 5'd3, 64'd0);
    rd(1'b1, 5'd5, 64'd0);

    wr(5'd9, 64'hAA);
    rd(1'b1, 5'd9, 64'hAA);
    bus.rd0_valid = 1'b1;
    bus.rd0_addr  = 5'd9;
    #1;
    chk("mid_gnt", 64'(bus.rd0_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    bus.rd0_valid = 1'b0;
    chk("mr_rsp_v", 64'(bus.rsp_valid), 64'd0);
    chk("mr_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("mr_rsp_d", bus.rsp_data, 64'd0);
    chk("mr_busy", 64'(bus.init_busy), 64'd1);
    step();
    chk("mr_drop", 64'(bus.rsp_valid), 64'd0);

    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("sw_busy", 64'(bus.init_busy), 64'd1);
    step();
    rst_n = 1'b1;
    bus.rd0_valid = 1'b1;
    bus.rd0_addr  = 5'd9;
    #1;
    chk("sw_rd_rdy", 64'(bus.rd0_ready), 64'd0);
    bus.rd0_valid = 1'b0;
    busy_cnt(n);
    chk("sw_len", 64'(n), 64'd32);
    chk("sw_no_rsp", 64'(bus.rsp_valid), 64'd0);
    rd(1'b0, 5'd9, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_sdp_arb.md
RAM_SDP_ARB -- requirements
Module: ram_sdp_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of RAM entries; AWIDTH = $clog2(DEPTH) is derived, not overridable.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear_req  input  1  single-cycle pulse requesting a full table clear.
REQ-006 SHALL have port init_busy  output  1  high while the clear sweep runs.
REQ-007 SHALL have port wr_valid  input  1  write request.
REQ-008 SHALL have port wr_ready  output  1  write accepted when wr_valid is also high.
REQ-009 SHALL have ports wr_addr  input  AWIDTH  and wr_data  input  DWIDTH, the write address and data.
REQ-010 SHALL have ports rd0_valid, rd1_valid  input  1  read requests from client 0 and client 1.
REQ-011 SHALL have ports rd0_addr, rd1_addr  input  AWIDTH  read addresses.
REQ-012 SHALL have ports rd0_ready, rd1_ready  output  1  read grants.
REQ-013 SHALL have ports rsp_valid  output  1,  rsp_id  output  1,  rsp_data  output  DWIDTH  for the read response.

Function
REQ-014 SHALL implement FSM states CLEAR and RUN; the state after reset is CLEAR.
REQ-015 In CLEAR, the block SHALL write all-zeros to address clr_cnt each cycle and increment clr_cnt; when clr_cnt = DEPTH-1 is written, the next state SHALL be RUN; a sweep takes exactly DEPTH cycles.
REQ-016 init_busy SHALL equal (state == CLEAR); in CLEAR, wr_ready, rd0_ready and rd1_ready SHALL be 0.
REQ-017 clear_req in RUN SHALL move the FSM to CLEAR with clr_cnt = 0 on the next edge; clear_req in CLEAR SHALL restart the sweep at clr_cnt = 0.
REQ-018 In RUN, wr_ready SHALL be 1; a write occurs on any edge where wr_valid && wr_ready, with no backpressure.
REQ-019 In RUN, at most one read SHALL be granted per cycle; ready outputs are combinational from the valid inputs and the round-robin pointer.
REQ-020 Arbitration: if only one client is valid, that client SHALL be granted; if both are valid, the client not granted most recently SHALL be granted; the pointer updates only on a grant; its reset value favours client 0.
REQ-021 A read granted in cycle N SHALL produce rsp_valid = 1 in cycle N+1, with rsp_id = the granted client and rsp_data = the RAM contents; the response has no backpressure.
REQ-022 A read and a write to the same address in the same cycle SHALL return the new wr_data (write-to-read bypass); different addresses SHALL return the old contents.
REQ-023 A read granted in the cycle clear_req arrives SHALL still complete its response normally.
REQ-024 rsp_valid SHALL be 0 in every cycle that does not follow a grant; rsp_id and rsp_data SHALL hold their last values when rsp_valid = 0.

Reset
REQ-025 Asserting rst_n low SHALL immediately set: state = CLEAR, clr_cnt = 0, round-robin pointer = favour client 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
REQ-026 Reset mid-sweep or mid-read SHALL discard pending responses; after release, a full DEPTH-cycle clear SHALL run.
REQ-027 RAM contents are not reset directly; they SHALL be zeroed only by the clear sweep.

Structure
REQ-028 A shared package ram_arb_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the client id typedef (1 bit).
REQ-029 Storage SHALL be one instance of sub-module ram_sdp_one_clock (DWIDTH, DEPTH passed through); the write port is muxed between the clear sweep and wr_*, and the read port is driven by the granted address.

Verification (DWIDTH=64, DEPTH=32)
REQ-030 Reset release -> init_busy high for exactly 32 cycles, then low; subsequent reads of addresses 0..31 return 0.
REQ-031 Write addr 5 = 0xDEAD_BEEF, then rd0 reads addr 5 -> rsp_valid one cycle later, rsp_id = 0, rsp_data = 0xDEAD_BEEF.
REQ-032 rd0 and rd1 held valid for 4 cycles -> grants in order 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-033 Same cycle: write addr 7 = 0x1234 and rd1 reads addr 7 -> rsp_data = 0x1234, rsp_id = 1.
REQ-034 clear_req pulsed in RUN after writing addr 3 = 0xFF -> init_busy high for 32 cycles; then a read of addr 3 returns 0.
REQ-035 rst_n asserted at sweep cycle 10 -> outputs reset immediately; after release, init_busy stays high for a full 32 cycles.
